// File: rtl/btn_debouncer.sv
// btn_debouncer
//   Push-button conditioner. Every raw pin goes through a two-flop
//   synchronizer and an independent debounce FSM that produces a clean
//   level, a one-clock press pulse and an auto-repeat pulse train.
//   All logic runs on ClkPort; Reset is asynchronous and active-high.

// ---------------------------------------------------------------------------
// btn_debounce_fsm
//   One button's qualifier. It sees only the synchronized level i_s.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INI   | idle, button released, waiting for i_s to go high
//   WQ    | i_s high, counting the debounce window before accepting
//   SCEN  | press accepted: one clock of o_scen and o_mcen
//   HOLD  | pressed and held, counting toward the next repeat pulse
//   MCEN  | repeat interval elapsed: one clock of o_mcen
//   CCR   | i_s low while pressed, counting the release debounce window
// ---------------------------------------------------------------------------
module btn_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int CNT_W           = 25
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic i_s,
  output logic o_db,
  output logic o_scen,
  output logic o_mcen
);

  localparam logic [2:0] ST_INI  = 3'd0;
  localparam logic [2:0] ST_WQ   = 3'd1;
  localparam logic [2:0] ST_SCEN = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_MCEN = 3'd4;
  localparam logic [2:0] ST_CCR  = 3'd5;

  // Terminal counts: the window is DEBOUNCE_CYCLES/REPEAT_CYCLES clocks
  // counted from zero, so the compare is against N-1.
  localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_db_tc;
  logic             w_rep_tc;

  assign w_db_tc  = (r_cnt == DB_TC);
  assign w_rep_tc = (r_cnt == REP_TC);

  // Next-state and counter update. The counter is cleared on every state
  // change and on every terminal compare, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INI: begin
        if (i_s) begin
          w_state_nxt = ST_WQ;
          w_cnt_nxt   = '0;
        end
      end
      ST_WQ: begin
        if (!i_s) begin
          w_state_nxt = ST_INI;
          w_cnt_nxt   = '0;
        end else if (w_db_tc) begin
          w_state_nxt = ST_SCEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_1;
        end
      end
      ST_SCEN: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
      end
      ST_HOLD: begin
        // A release seen in the same clock as the repeat expiry wins:
        // go debounce the release and drop the repeat pulse.
        if (!i_s) begin
          w_state_nxt = ST_CCR;
          w_cnt_nxt   = '0;
        end else if (w_rep_tc) begin
          w_state_nxt = ST_MCEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_1;
        end
      end
      ST_MCEN: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
      end
      ST_CCR: begin
        // Release bounce puts us back in HOLD with a fresh repeat interval.
        if (i_s) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else if (w_db_tc) begin
          w_state_nxt = ST_INI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_1;
        end
      end
      default: begin
        w_state_nxt = ST_INI;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers, aborted immediately by Reset.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_INI;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    o_db   = 1'b0;
    o_scen = 1'b0;
    o_mcen = 1'b0;
    case (r_state)
      ST_SCEN: begin
        o_db   = 1'b1;
        o_scen = 1'b1;
        o_mcen = 1'b1;
      end
      ST_HOLD: o_db = 1'b1;
      ST_MCEN: begin
        o_db   = 1'b1;
        o_mcen = 1'b1;
      end
      ST_CCR:  o_db = 1'b1;
      default: begin
        o_db   = 1'b0;
        o_scen = 1'b0;
        o_mcen = 1'b0;
      end
    endcase
  end

endmodule

// ---------------------------------------------------------------------------
// btn_debouncer: synchronizer bank plus one debounce FSM per button.
// ---------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic             ClkPort,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_scen,
  output logic [N_BTN-1:0] btn_mcen
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                             : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Two-flop synchronizer; the FSMs only ever look at r_sync2.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W)
    ) u_fsm (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .i_s     (r_sync2[gi]),
      .o_db    (btn_db[gi]),
      .o_scen  (btn_scen[gi]),
      .o_mcen  (btn_mcen[gi])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed tables and sequences plus random stimulus
// against a run-length reference model of the debouncer.
module tb_btn_debouncer;

  localparam int N  = 5;
  localparam int DB = 8;
  localparam int RP = 20;

  logic         ClkPort;
  logic         Reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_scen;
  logic [N-1:0] btn_mcen;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  btn_debouncer #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .btn_raw  (btn_raw),
    .btn_db   (btn_db),
    .btn_scen (btn_scen),
    .btn_mcen (btn_mcen)
  );

  initial begin
    ClkPort = 1'b0;
    forever #5 ClkPort = ~ClkPort;
  end

  initial begin
    #900_000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  // Reference model: the synchronized level is raw delayed by two clocks.
  // A press is accepted after DB+1 consecutive high samples; a release after
  // DB+1 consecutive low samples; while pressed, a repeat fires once the
  // level has been high for RP+1 consecutive samples, where the sample taken
  // while leaving a pulse always counts as high.
  logic [N-1:0] m_p0, m_p1;
  int           m_run1[N];
  int           m_run0[N];
  bit           m_pressed[N];
  int           m_pulse[N];   // 0 none, 1 press pulse, 2 repeat pulse

  task automatic model_reset();
    m_p0 = '0;
    m_p1 = '0;
    for (int i = 0; i < N; i++) begin
      m_run1[i] = 0; m_run0[i] = 0; m_pressed[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    s    = m_p1;
    m_p1 = m_p0;
    m_p0 = raw;
    for (int i = 0; i < N; i++) begin
      if (m_pulse[i] != 0) begin
        m_pulse[i] = 0;
        m_run1[i]  = 1;
        m_run0[i]  = 0;
      end else if (!m_pressed[i]) begin
        m_run1[i] = s[i] ? m_run1[i] + 1 : 0;
        if (m_run1[i] == DB + 1) begin
          m_pressed[i] = 1;
          m_pulse[i]   = 1;
          m_run1[i]    = 0;
        end
      end else if (s[i]) begin
        m_run0[i] = 0;
        m_run1[i] = m_run1[i] + 1;
        if (m_run1[i] == RP + 1) begin
          m_pulse[i] = 2;
          m_run1[i]  = 0;
        end
      end else begin
        m_run1[i] = 0;
        m_run0[i] = m_run0[i] + 1;
        if (m_run0[i] == DB + 1) begin
          m_pressed[i] = 0;
          m_run0[i]    = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] e_db, e_sc, e_mc;
    for (int i = 0; i < N; i++) begin
      e_db[i] = m_pressed[i];
      e_sc[i] = (m_pulse[i] == 1);
      e_mc[i] = (m_pulse[i] != 0);
    end
    check("model_db",   btn_db,   e_db);
    check("model_scen", btn_scen, e_sc);
    check("model_mcen", btn_mcen, e_mc);
  endtask

  task automatic tick();
    @(posedge ClkPort);
    if (!Reset) model_edge(btn_raw);
    @(negedge ClkPort);
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_db"},   btn_db,   '0);
    check({tag, "_scen"}, btn_scen, '0);
    check({tag, "_mcen"}, btn_mcen, '0);
  endtask

  // Called at a falling edge: asserts Reset and checks the async clear.
  task automatic assert_reset(input string tag);
    Reset = 1'b1;
    model_reset();
    #1;
    check_zero(tag);
  endtask

  typedef struct {
    int           cyc;
    logic [N-1:0] raw;
    logic [N-1:0] db;
    logic [N-1:0] scen;
    logic [N-1:0] mcen;
  } vec_t;

  vec_t vt[12];
  int   rem[N];
  int   edge_n;
  int   n_sc, n_mc;
  logic act1;
  logic [N-1:0] rv;

  initial begin
    // Press-hold-release timeline for button 0, edges counted from press.
    vt[0]  = '{10, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    vt[1]  = '{11, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    vt[2]  = '{12, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[3]  = '{31, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[4]  = '{32, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
    vt[5]  = '{33, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[6]  = '{52, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[7]  = '{53, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
    vt[8]  = '{54, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[9]  = '{60, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    vt[10] = '{70, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
    vt[11] = '{71, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

    // 1: reset behaviour
    Reset   = 1'b1;
    btn_raw = '0;
    model_reset();
    #1;
    check_zero("rst_async");
    ticks(5);
    check_zero("rst_held");
    Reset = 1'b0;
    ticks(5);
    check_zero("rst_released");

    // 2: table-driven press / repeat / release on button 0
    edge_n = 0;
    for (int k = 0; k < 12; k++) begin
      while (edge_n < vt[k].cyc) begin
        btn_raw = vt[k].raw;
        tick();
        edge_n++;
      end
      check($sformatf("tbl%0d_db", k),   btn_db,   vt[k].db);
      check($sformatf("tbl%0d_scen", k), btn_scen, vt[k].scen);
      check($sformatf("tbl%0d_mcen", k), btn_mcen, vt[k].mcen);
    end
    ticks(5);

    // 3: short glitches on button 1 never qualify
    act1 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      btn_raw = 5'b00010;
      for (int k = 0; k < 5; k++) begin
        tick(); act1 |= btn_db[1] | btn_scen[1] | btn_mcen[1];
      end
      btn_raw = 5'b00000;
      for (int k = 0; k < 3; k++) begin
        tick(); act1 |= btn_db[1] | btn_scen[1] | btn_mcen[1];
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(); act1 |= btn_db[1] | btn_scen[1] | btn_mcen[1];
    end
    check("glitch_activity", {4'b0, act1}, 5'b00000);

    // 4: release bounce on button 2
    n_sc = 0; n_mc = 0;
    btn_raw = 5'b00100;
    for (int k = 0; k < 11; k++) begin
      tick(); n_sc += btn_scen[2]; n_mc += btn_mcen[2];
    end
    check("bounce_accept_scen", btn_scen, 5'b00100);
    for (int j = 0; j < 15; j++) begin
      btn_raw = ((j / 3) % 2 == 1) ? 5'b00100 : 5'b00000;
      tick(); n_sc += btn_scen[2]; n_mc += btn_mcen[2];
      check("bounce_db_held", btn_db, 5'b00100);
    end
    btn_raw = 5'b00000;
    for (int k = 0; k < 7; k++) begin
      tick(); n_sc += btn_scen[2]; n_mc += btn_mcen[2];
    end
    check("bounce_db_edge33", btn_db, 5'b00100);
    tick(); n_sc += btn_scen[2]; n_mc += btn_mcen[2];
    check("bounce_db_edge34", btn_db, 5'b00000);
    for (int k = 0; k < 10; k++) begin
      tick(); n_sc += btn_scen[2]; n_mc += btn_mcen[2];
    end
    check("bounce_scen_count", N'(n_sc), 5'd1);
    check("bounce_mcen_count", N'(n_mc), 5'd1);

    // 5: simultaneous presses on buttons 3 and 4
    btn_raw = 5'b11000;
    ticks(10);
    check("simul_pre_scen", btn_scen, 5'b00000);
    tick();
    check("simul_scen", btn_scen, 5'b11000);
    check("simul_mcen", btn_mcen, 5'b11000);
    check("simul_db",   btn_db,   5'b11000);
    tick();
    check("simul_post_scen", btn_scen, 5'b00000);
    btn_raw = 5'b00000;
    ticks(14);
    check("simul_release_db", btn_db, 5'b00000);

    // Release coinciding with repeat expiry: no repeat pulse
    btn_raw = 5'b00001;
    ticks(29);
    btn_raw = 5'b00000;
    ticks(3);
    check("prec_mcen_edge32", btn_mcen, 5'b00000);
    check("prec_db_edge32",   btn_db,   5'b00001);
    ticks(14);
    check("prec_released", btn_db, 5'b00000);

    // 6: reset mid-WQ and mid-HOLD while the button stays held
    btn_raw = 5'b00001;
    ticks(6);
    assert_reset("rst_wq");
    ticks(3);
    Reset = 1'b0;
    ticks(10);
    check("rst_wq_pre_scen", btn_scen, 5'b00000);
    tick();
    check("rst_wq_scen", btn_scen, 5'b00001);
    ticks(4);
    check("rst_hold_db", btn_db, 5'b00001);
    assert_reset("rst_hold");
    ticks(2);
    Reset = 1'b0;
    ticks(10);
    check("rst_hold_pre_scen", btn_scen, 5'b00000);
    tick();
    check("rst_hold_scen", btn_scen, 5'b00001);
    btn_raw = 5'b00000;
    ticks(15);

    // Random stimulus with hold times straddling both windows
    rv = '0;
    for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(1, 30));
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          rv[i]  = ~rv[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10))
                                               : int'($urandom_range(8, 60));
        end
        rem[i]--;
      end
      btn_raw = rv;
      if ($urandom_range(0, 699) == 0) begin
        assert_reset("rnd_rst");
        ticks(2);
        Reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
